// File: rtl/sti_dac_sched.sv
// -----------------------------------------------------------------------------
// sti_dac_sched
//
// Command scheduler in front of the STI_DAC serializer. Serial-transmit
// commands are buffered in a small FIFO and handed to the serializer one at a
// time: a one-cycle load strobe with the pi_* fields already stable, then the
// scheduler waits for the transfer (so_valid) to start and finish, idles for
// GAP_CYCLES, and moves on. A flush request drains the FIFO, emits a
// one-cycle pi_end, waits for pixel_finish and then parks in DONE.
//
// Handshake: a command is transferred on every rising clk edge where
// cmd_valid && cmd_ready; cmd_valid may be raised independently of
// cmd_ready and the payload must be held while cmd_valid is high and
// cmd_ready is low.
//
// Parameters:
//   FIFO_DEPTH  command FIFO entries (power of 2, >= 2)
//   GAP_CYCLES  idle cycles after so_valid falls before the next load (>= 1)
//   TIMEOUT     max cycles in WAIT_START or WAIT_DONE before err_timeout
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_data/length/fill/msb/low    command payload
//   flush_req                       pulse: finish queued work, then end frame
//   load, pi_*                      load strobe and registered fields
//   pi_end                          one-cycle end-of-frame strobe
//   so_valid, pixel_finish          serializer status
//   busy, done, err_timeout         status (done/err_timeout sticky)
//   fifo_count                      FIFO occupancy
//   perf_issued, perf_stall         performance counters (0 unless enabled)
//   dbg_state                       current FSM state
//
// Optional feature: define STI_DAC_SCHED_PERF_EN to build the saturating
// perf_issued / perf_stall counters; otherwise those outputs are tied to 0.
// -----------------------------------------------------------------------------
module sti_dac_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [15:0]                 cmd_data,
  input  logic [1:0]                  cmd_length,
  input  logic                        cmd_fill,
  input  logic                        cmd_msb,
  input  logic                        cmd_low,
  input  logic                        flush_req,
  output logic                        load,
  output logic [15:0]                 pi_data,
  output logic [1:0]                  pi_length,
  output logic                        pi_fill,
  output logic                        pi_msb,
  output logic                        pi_low,
  output logic                        pi_end,
  input  logic                        so_valid,
  input  logic                        pixel_finish,
  output logic                        busy,
  output logic                        done,
  output logic                        err_timeout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 perf_issued,
  output logic [15:0]                 perf_stall,
  output logic [2:0]                  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_GAP        = 3'd4,
    S_END        = 3'd5,
    S_WAIT_FIN   = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO. Entry layout: {data[15:0], length[1:0], fill, msb, low}.
  // ---------------------------------------------------------------------------
  logic [20:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, fifo_empty, push, pop;

  state_t        state_q;
  logic          flush_pend_q, done_q, err_q, load_q, pi_end_q;
  logic [15:0]   pi_data_q;
  logic [1:0]    pi_length_q;
  logic          pi_fill_q, pi_msb_q, pi_low_q;
  logic [TW-1:0] tmo_q;
  logic [GW-1:0] gap_q;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !fifo_full && !flush_pend_q && !done_q;
  assign push       = cmd_valid && cmd_ready;
  // The head was copied into pi_* on the way into ISSUE; retire it now.
  assign pop        = (state_q == S_ISSUE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_data, cmd_length, cmd_fill, cmd_msb, cmd_low};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH.
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Flush is latched once and only cleared by reset; late requests are moot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_pend_q <= 1'b0;
    end else if (flush_req && !done_q) begin
      flush_pend_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered strobes and fields.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      load_q      <= 1'b0;
      pi_end_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pi_data_q   <= '0;
      pi_length_q <= '0;
      pi_fill_q   <= 1'b0;
      pi_msb_q    <= 1'b0;
      pi_low_q    <= 1'b0;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      load_q   <= 1'b0;
      pi_end_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            // Fields are loaded together with the strobe so they are
            // already valid in the cycle load is high.
            state_q <= S_ISSUE;
            load_q  <= 1'b1;
            {pi_data_q, pi_length_q, pi_fill_q, pi_msb_q, pi_low_q} <= mem_q[rd_ptr_q];
          end else if (flush_pend_q) begin
            state_q  <= S_END;
            pi_end_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT_START;
          tmo_q   <= '0;
        end
        S_WAIT_START: begin
          if (so_valid) begin
            state_q <= S_WAIT_DONE;
            tmo_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            // Serializer never started: drop the command and carry on.
            err_q   <= 1'b1;
            state_q <= S_GAP;
            gap_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!so_valid) begin
            state_q <= S_GAP;
            gap_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_GAP;
            gap_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) state_q <= S_IDLE;
          else                   gap_q   <= gap_q + GW'(1);
        end
        S_END: begin
          state_q <= S_WAIT_FIN;
        end
        S_WAIT_FIN: begin
          if (pixel_finish) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load        = load_q;
  assign pi_end      = pi_end_q;
  assign pi_data     = pi_data_q;
  assign pi_length   = pi_length_q;
  assign pi_fill     = pi_fill_q;
  assign pi_msb      = pi_msb_q;
  assign pi_low      = pi_low_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign fifo_count  = count_q;
  assign dbg_state   = state_q;

`ifdef STI_DAC_SCHED_PERF_EN
  logic [15:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (load_q && (perf_issued_q != 16'hFFFF)) begin
        perf_issued_q <= perf_issued_q + 16'd1;
      end
      if (cmd_valid && !cmd_ready && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`else
  assign perf_issued = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_sti_dac_sched.sv
`timescale 1ns/1ps
module tb_sti_dac_sched;

  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 64;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_length;
  logic        cmd_fill, cmd_msb, cmd_low, flush_req;
  logic        load, pi_fill, pi_msb, pi_low, pi_end;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        so_valid, pixel_finish, busy, done, err_timeout;
  logic [2:0]  fifo_count;
  logic [15:0] perf_issued, perf_stall;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Scoreboard: commands accepted by the scheduler, in acceptance order.
  logic [20:0] exp_q[$];

  // Serializer model controls: 0 = normal, 1 = so_valid stuck high, 2 = silent.
  int ser_mode = 0;
  int ser_len  = 4;
  int ser_cnt  = 0;
  bit chk_gap  = 0;
  int low_run  = 0;
  int load_cnt = 0;
  int end_cnt  = 0;
  logic prev_load = 1'b0;
  logic prev_end  = 1'b0;

  sti_dac_sched #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_length(cmd_length),
    .cmd_fill(cmd_fill), .cmd_msb(cmd_msb), .cmd_low(cmd_low),
    .flush_req(flush_req),
    .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .so_valid(so_valid), .pixel_finish(pixel_finish),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .fifo_count(fifo_count),
    .perf_issued(perf_issued), .perf_stall(perf_stall),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ serializer model
  // On a load the transfer runs for ser_len cycles of so_valid.
  initial begin
    so_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (ser_mode == 1) begin
        so_valid = 1'b1;
        ser_cnt  = 0;
      end else if (ser_mode == 2) begin
        so_valid = 1'b0;
        ser_cnt  = 0;
      end else if (ser_cnt > 0) begin
        ser_cnt--;
        so_valid = (ser_cnt != 0);
      end else if (load === 1'b1) begin
        ser_cnt  = ser_len;
        so_valid = 1'b1;
      end else begin
        so_valid = 1'b0;
      end
    end
  end

  // Cycles since so_valid was last seen high at a clock edge.
  always @(posedge clk) low_run <= so_valid ? 0 : low_run + 1;

  // --------------------------------------------------------------- monitor
  always @(negedge clk) begin
    logic [20:0] e;
    if (reset === 1'b1) begin
      checks++;
      if (load === 1'b1 && pi_end === 1'b1) begin
        errors++;
        $display("FAIL strobe_overlap: load=%b pi_end=%b, required not both 1", load, pi_end);
      end
      checks++;
      if ((load === 1'b1 && prev_load === 1'b1) || (pi_end === 1'b1 && prev_end === 1'b1)) begin
        errors++;
        $display("FAIL strobe_repeat: load %b->%b pi_end %b->%b, required single-cycle", prev_load, load, prev_end, pi_end);
      end
      if (load === 1'b1) begin
        load_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: pi=%h with no command queued", {pi_data, pi_length, pi_fill, pi_msb, pi_low});
        end else begin
          e = exp_q.pop_front();
          if ({pi_data, pi_length, pi_fill, pi_msb, pi_low} !== e) begin
            errors++;
            $display("FAIL load_fields: got %h, required %h", {pi_data, pi_length, pi_fill, pi_msb, pi_low}, e);
          end
        end
        if (chk_gap) begin
          checks++;
          if (low_run < GAP_CYCLES + 1) begin
            errors++;
            $display("FAIL load_gap: load %0d cycles after so_valid low, required >= %0d", low_run, GAP_CYCLES + 1);
          end
        end
      end
      if (pi_end === 1'b1) begin
        end_cnt++;
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL end_early: pi_end with %0d commands outstanding, required 0", exp_q.size());
        end
      end
    end
    prev_load = load;
    prev_end  = pi_end;
  end

  // ---------------------------------------------------------------- driver
  function automatic logic [20:0] rand_entry();
    logic [20:0] e;
    e = 21'($urandom);
    return e;
  endfunction

  task automatic push_cmd(input logic [20:0] e);
    int n;
    n = 0;
    @(negedge clk);
    {cmd_data, cmd_length, cmd_fill, cmd_msb, cmd_low} = e;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: busy=%b outstanding=%0d, required idle", name, busy, exp_q.size());
    end
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_length = '0;
    cmd_fill = 1'b0; cmd_msb = 1'b0; cmd_low = 1'b0;
    flush_req = 1'b0; pixel_finish = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, busy, done, err_timeout, fifo_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: load=%b pi_data=%h pi_end=%b busy=%b done=%b err=%b count=%0d, required all 0",
               load, pi_data, pi_end, busy, done, err_timeout, fifo_count);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    logic [20:0] e;
    ser_mode = 0; ser_len = 17; chk_gap = 1;
    e = {16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0};
    push_cmd(e);
    @(negedge clk);
    checks++;
    if (load !== 1'b0) begin
      errors++;
      $display("FAIL single_early: load=%b one cycle after push, required 0", load);
    end
    @(negedge clk);
    checks++;
    if (load !== 1'b1 || pi_data !== 16'hA5C3 || pi_length !== 2'b01) begin
      errors++;
      $display("FAIL single_latency: load=%b pi_data=%h pi_length=%b, required 1 a5c3 01", load, pi_data, pi_length);
    end
    // A second command queued mid-transfer must respect the post-transfer gap.
    push_cmd(rand_entry());
    wait_idle("single");
  endtask

  task automatic test_fifo_full();
    chk_gap = 0; ser_mode = 1; ser_len = 3;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push_cmd(rand_entry());
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: count=%0d ready=%b, required 4 0", fifo_count, cmd_ready);
    end
    ser_mode = 0;
    wait_idle("fifo_full");
    checks++;
    if (fifo_count !== 3'd0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL fifo_empty: count=%0d err=%b, required 0 0", fifo_count, err_timeout);
    end
  endtask

  task automatic test_push_pop();
    logic [20:0] e;
    chk_gap = 1; ser_mode = 0; ser_len = 3;
    push_cmd(rand_entry());
    push_cmd(rand_entry());
    e = rand_entry();
    @(negedge clk);
    checks++;
    if (load !== 1'b1 || fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL pushpop_pre: load=%b count=%0d, required 1 2", load, fifo_count);
    end
    {cmd_data, cmd_length, cmd_fill, cmd_msb, cmd_low} = e;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL pushpop_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    @(posedge clk);
    if (cmd_ready === 1'b1) exp_q.push_back(e);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL pushpop_count: count=%0d, required 2", fifo_count);
    end
    wait_idle("push_pop");
  endtask

  task automatic test_random();
    chk_gap = 1; ser_mode = 0;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      ser_len = $urandom_range(1, 12);
      push_cmd(rand_entry());
    end
    wait_idle("random");
    checks++;
    if (fifo_count !== 3'd0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL random_end: count=%0d err=%b, required 0 0", fifo_count, err_timeout);
    end
  endtask

  task automatic test_timeout();
    int n;
    int l0;
    chk_gap = 0; ser_mode = 2;
    l0 = load_cnt;
    push_cmd(rand_entry());
    push_cmd(rand_entry());
    n = 0;
    while (load !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (err_timeout !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ser_mode = 0;
    checks++;
    if (err_timeout !== 1'b1 || n < TIMEOUT || n > TIMEOUT + 2) begin
      errors++;
      $display("FAIL timeout_fire: err=%b after %0d cycles, required 1 after %0d..%0d", err_timeout, n, TIMEOUT, TIMEOUT + 2);
    end
    wait_idle("timeout");
    checks++;
    if (load_cnt - l0 != 2 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next: loads=%0d err=%b, required 2 1", load_cnt - l0, err_timeout);
    end
  endtask

  task automatic test_mid_reset();
    int l0;
    chk_gap = 0; ser_mode = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_cmd(rand_entry());
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: count=%0d busy=%b, required 3 1", fifo_count, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, busy, done, err_timeout, fifo_count} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: load=%b pi_data=%h pi_end=%b busy=%b err=%b count=%0d, required all 0",
               load, pi_data, pi_end, busy, err_timeout, fifo_count);
    end
    exp_q.delete();
    ser_mode = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    l0 = load_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (load_cnt != l0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: loads=%0d busy=%b, required 0 0", load_cnt - l0, busy);
    end
  endtask

  task automatic test_flush();
    int n;
    int l0;
    chk_gap = 1; ser_mode = 0; ser_len = 5;
    l0 = load_cnt;
    push_cmd(rand_entry());
    push_cmd(rand_entry());
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: cmd_ready=%b, required 0", cmd_ready);
    end
    n = 0;
    while (end_cnt == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (end_cnt != 1 || load_cnt - l0 != 2) begin
      errors++;
      $display("FAIL flush_end: pi_end pulses=%0d loads=%0d, required 1 2", end_cnt, load_cnt - l0);
    end
    repeat (3) @(negedge clk);
    pixel_finish = 1'b1;
    @(negedge clk);
    pixel_finish = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: done=%b, required 1", done);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done !== 1'b1 || end_cnt != 1 || load_cnt - l0 != 2 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_sticky: done=%b ends=%0d loads=%0d ready=%b, required 1 1 2 0",
               done, end_cnt, load_cnt - l0, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_push_pop();
    test_random();
    test_timeout();
    test_mid_reset();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
